// File: rtl/level_progress_sequencer_pkg.sv
// level_progress_sequencer_pkg: shared state encoding and lane period defaults
package level_progress_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAYING   = 3'd1,
        LEVEL_UP  = 3'd2,
        DYING     = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } state_t;

    localparam int DEF_BASE_PERIOD = 200;
    localparam int DEF_PERIOD_STEP = 10;
    localparam int DEF_MIN_PERIOD  = 40;

endpackage

// File: rtl/level_progress_sequencer_banner_timer.sv
// level_banner_timer: loadable down-counter timing the LEVEL_UP and DYING banners
module level_banner_timer #(
    parameter int TIMER_WIDTH   = 26,
    parameter int BANNER_CYCLES = 50000000
) (
    input  logic SC_LEVELPROGRESSCOUNTER_CLOCK_50,
    input  logic SC_LEVELPROGRESSCOUNTER_RESET_InHigh,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [TIMER_WIDTH-1:0] count_q;

    // load the full banner length, otherwise count down to zero and stop
    always_ff @(posedge SC_LEVELPROGRESSCOUNTER_CLOCK_50 or posedge SC_LEVELPROGRESSCOUNTER_RESET_InHigh)
        if (SC_LEVELPROGRESSCOUNTER_RESET_InHigh)
            count_q <= '0;
        else if (load_i)
            count_q <= TIMER_WIDTH'(BANNER_CYCLES - 1);
        else if (dec_i && count_q != '0)
            count_q <= count_q - TIMER_WIDTH'(1);

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/level_progress_sequencer.sv
// level_progress_sequencer: turns game events into level-counter strobes, tracks lives/level and lane speed
module level_progress_sequencer
    import level_progress_sequencer_pkg::*;
#(
    parameter int LEVEL_WIDTH   = 5,
    parameter int MAX_LEVEL     = 16,
    parameter int LIVES_WIDTH   = 2,
    parameter int LIVES_INIT    = 3,
    parameter int BANNER_CYCLES = 50000000,
    parameter int TIMER_WIDTH   = 26,
    parameter int PERIOD_WIDTH  = 8,
    parameter int BASE_PERIOD   = DEF_BASE_PERIOD,
    parameter int PERIOD_STEP   = DEF_PERIOD_STEP,
    parameter int MIN_PERIOD    = DEF_MIN_PERIOD
) (
    input  logic                    SC_LEVELPROGRESSCOUNTER_CLOCK_50,
    input  logic                    SC_LEVELPROGRESSCOUNTER_RESET_InHigh,
    input  logic                    start_in,
    input  logic                    goal_in,
    input  logic                    hit_in,
    output logic                    count_n_out,
    output logic                    clear_out,
    output logic                    enable_out,
    output logic                    freeze_out,
    output logic [2:0]              state_out,
    output logic [LEVEL_WIDTH-1:0]  level_out,
    output logic [LIVES_WIDTH-1:0]  lives_out,
    output logic [PERIOD_WIDTH-1:0] lane_period_out
);

    localparam int WW = PERIOD_WIDTH + LEVEL_WIDTH;

    state_t                  state_q, state_d;
    logic [LEVEL_WIDTH-1:0]  level_q, level_d;
    logic [LIVES_WIDTH-1:0]  lives_q, lives_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    count_n_q, count_n_d;
    logic                    clear_q, clear_d;
    logic                    enable_q, freeze_q;
    logic                    load, tmr_zero;
    logic [WW-1:0]           prod_w;

    level_banner_timer #(
        .TIMER_WIDTH  (TIMER_WIDTH),
        .BANNER_CYCLES(BANNER_CYCLES)
    ) u_timer (
        .SC_LEVELPROGRESSCOUNTER_CLOCK_50    (SC_LEVELPROGRESSCOUNTER_CLOCK_50),
        .SC_LEVELPROGRESSCOUNTER_RESET_InHigh(SC_LEVELPROGRESSCOUNTER_RESET_InHigh),
        .load_i                              (load),
        .dec_i                               (state_q == LEVEL_UP || state_q == DYING),
        .zero_o                              (tmr_zero)
    );

    // next state, counters and strobes; hit takes priority over goal
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        lives_d   = lives_q;
        count_n_d = 1'b1;
        clear_d   = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE, GAME_OVER, WIN:
                if (start_in) begin
                    state_d = PLAYING;
                    level_d = '0;
                    lives_d = LIVES_WIDTH'(LIVES_INIT);
                    clear_d = 1'b1;
                end
            PLAYING:
                if (hit_in) begin
                    lives_d = lives_q - LIVES_WIDTH'(1);
                    state_d = (lives_q == LIVES_WIDTH'(1)) ? GAME_OVER : DYING;
                    load    = (lives_q != LIVES_WIDTH'(1));
                end else if (goal_in) begin
                    count_n_d = 1'b0;
                    if (level_q == LEVEL_WIDTH'(MAX_LEVEL - 1))
                        state_d = WIN;
                    else begin
                        level_d = level_q + LEVEL_WIDTH'(1);
                        state_d = LEVEL_UP;
                        load    = 1'b1;
                    end
                end
            LEVEL_UP, DYING:
                state_d = tmr_zero ? PLAYING : state_q;
            default:
                state_d = IDLE;
        endcase
    end

    assign prod_w   = WW'(level_q) * WW'(PERIOD_STEP);
    assign period_d = (prod_w + WW'(MIN_PERIOD) >= WW'(BASE_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD)
                                                                     : PERIOD_WIDTH'(WW'(BASE_PERIOD) - prod_w);

    // register state and every output so nothing reaches the counter combinationally
    always_ff @(posedge SC_LEVELPROGRESSCOUNTER_CLOCK_50 or posedge SC_LEVELPROGRESSCOUNTER_RESET_InHigh)
        if (SC_LEVELPROGRESSCOUNTER_RESET_InHigh) begin
            state_q   <= IDLE;
            level_q   <= '0;
            lives_q   <= LIVES_WIDTH'(LIVES_INIT);
            count_n_q <= 1'b1;
            clear_q   <= 1'b0;
            enable_q  <= 1'b0;
            freeze_q  <= 1'b1;
            period_q  <= PERIOD_WIDTH'(BASE_PERIOD);
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            count_n_q <= count_n_d;
            clear_q   <= clear_d;
            enable_q  <= (state_d != IDLE);
            freeze_q  <= (state_d != PLAYING);
            period_q  <= period_d;
        end

    assign count_n_out     = count_n_q;
    assign clear_out       = clear_q;
    assign enable_out      = enable_q;
    assign freeze_out      = freeze_q;
    assign state_out       = state_q;
    assign level_out       = level_q;
    assign lives_out       = lives_q;
    assign lane_period_out = period_q;

endmodule

// File: tb/tb_level_progress_sequencer.sv
// tb_level_progress_sequencer: directed scenarios plus a randomized run against a game-rule model
module tb_level_progress_sequencer;

    localparam int MAXL = 3;
    localparam int LIVES = 3;
    localparam int BANNER = 4;
    localparam int S_IDLE = 0, S_PLAY = 1, S_LU = 2, S_DIE = 3, S_OVER = 4, S_WIN = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, goal = 1'b0, hit = 1'b0;
    logic count_n, clear, enable, freeze;
    logic [2:0] state;
    logic [4:0] level;
    logic [1:0] lives;
    logic [7:0] period;

    int n_tests = 0;
    int n_fail = 0;

    level_progress_sequencer #(
        .MAX_LEVEL    (MAXL),
        .LIVES_INIT   (LIVES),
        .BANNER_CYCLES(BANNER)
    ) dut (
        .SC_LEVELPROGRESSCOUNTER_CLOCK_50    (clk),
        .SC_LEVELPROGRESSCOUNTER_RESET_InHigh(rst),
        .start_in                            (start),
        .goal_in                             (goal),
        .hit_in                              (hit),
        .count_n_out                         (count_n),
        .clear_out                           (clear),
        .enable_out                          (enable),
        .freeze_out                          (freeze),
        .state_out                           (state),
        .level_out                           (level),
        .lives_out                           (lives),
        .lane_period_out                     (period)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic g, input logic h, input logic s);
        goal = g; hit = h; start = s;
        @(posedge clk); #1;
        goal = 1'b0; hit = 1'b0; start = 1'b0;
    endtask

    function automatic int period_of(input int lvl);
        int p;
        p = 200 - lvl * 10;
        return (p < 40) ? 40 : p;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({state, level, lives, count_n, clear, enable, freeze, period} !== {3'd0, 5'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd200}) begin
            n_fail++;
            $display("FAIL reset: state=%0d level=%0d lives=%0d cn=%b clr=%b en=%b frz=%b per=%0d, want 0 0 3 1 0 0 1 200",
                     state, level, lives, count_n, clear, enable, freeze, period);
        end
        rst = 1'b0;
        tick(0, 0, 0);
        n_tests++;
        if (state !== 3'd0 || clear !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d clr=%b, want 0 0", state, clear);
        end
    endtask

    task automatic test_start;
        tick(0, 0, 1);
        n_tests++;
        if ({state, level, lives, count_n, clear, enable, freeze, period} !== {3'd1, 5'd0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd200}) begin
            n_fail++;
            $display("FAIL start: state=%0d level=%0d lives=%0d cn=%b clr=%b en=%b frz=%b per=%0d, want 1 0 3 1 1 1 0 200",
                     state, level, lives, count_n, clear, enable, freeze, period);
        end
        tick(0, 0, 1);
        n_tests++;
        if (clear !== 1'b0 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL clear_one_cycle: clr=%b state=%0d, want 0 1", clear, state);
        end
    endtask

    task automatic test_goal;
        tick(1, 0, 0);
        n_tests++;
        if (count_n !== 1'b0 || level !== 5'd1 || state !== 3'd2 || freeze !== 1'b1 || period !== 8'd200) begin
            n_fail++;
            $display("FAIL goal: cn=%b level=%0d state=%0d frz=%b per=%0d, want 0 1 2 1 200", count_n, level, state, freeze, period);
        end
        for (int i = 0; i < BANNER - 1; i++) begin
            tick(1, 0, 0);
            n_tests++;
            if (state !== 3'd2 || count_n !== 1'b1 || level !== 5'd1 || period !== 8'd190) begin
                n_fail++;
                $display("FAIL level_up_hold[%0d]: state=%0d cn=%b level=%0d per=%0d, want 2 1 1 190", i, state, count_n, level, period);
            end
        end
        tick(0, 0, 0);
        n_tests++;
        if (state !== 3'd1 || freeze !== 1'b0) begin
            n_fail++;
            $display("FAIL level_up_exit: state=%0d frz=%b, want 1 0", state, freeze);
        end
    endtask

    task automatic test_win;
        tick(1, 0, 0);
        repeat (BANNER) tick(0, 0, 0);
        n_tests++;
        if (state !== 3'd1 || level !== 5'd2) begin
            n_fail++;
            $display("FAIL reach_last: state=%0d level=%0d, want 1 2", state, level);
        end
        tick(1, 0, 0);
        n_tests++;
        if (state !== 3'd5 || level !== 5'd2 || count_n !== 1'b0) begin
            n_fail++;
            $display("FAIL win: state=%0d level=%0d cn=%b, want 5 2 0", state, level, count_n);
        end
        tick(1, 1, 0);
        n_tests++;
        if (state !== 3'd5 || level !== 5'd2 || count_n !== 1'b1 || freeze !== 1'b1 || enable !== 1'b1 || period !== 8'd180) begin
            n_fail++;
            $display("FAIL win_hold: state=%0d level=%0d cn=%b frz=%b en=%b per=%0d, want 5 2 1 1 1 180",
                     state, level, count_n, freeze, enable, period);
        end
        tick(0, 0, 1);
        n_tests++;
        if (state !== 3'd1 || level !== 5'd0 || clear !== 1'b1 || lives !== 2'd3 || period !== 8'd180) begin
            n_fail++;
            $display("FAIL win_restart: state=%0d level=%0d clr=%b lives=%0d per=%0d, want 1 0 1 3 180", state, level, clear, lives, period);
        end
        tick(0, 0, 0);
        n_tests++;
        if (period !== 8'd200 || clear !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_period: per=%0d clr=%b, want 200 0", period, clear);
        end
    endtask

    task automatic test_lives;
        for (int k = 0; k < 2; k++) begin
            tick(0, 1, 0);
            n_tests++;
            if (lives !== 2'(2 - k) || state !== 3'd3 || freeze !== 1'b1) begin
                n_fail++;
                $display("FAIL hit[%0d]: lives=%0d state=%0d frz=%b, want %0d 3 1", k, lives, state, freeze, 2 - k);
            end
            for (int i = 0; i < BANNER - 1; i++) begin
                tick(0, 1, 1);
                n_tests++;
                if (state !== 3'd3 || lives !== 2'(2 - k)) begin
                    n_fail++;
                    $display("FAIL dying_hold[%0d.%0d]: state=%0d lives=%0d, want 3 %0d", k, i, state, lives, 2 - k);
                end
            end
            tick(0, 0, 0);
            n_tests++;
            if (state !== 3'd1) begin
                n_fail++;
                $display("FAIL dying_exit[%0d]: state=%0d, want 1", k, state);
            end
        end
        tick(0, 1, 0);
        n_tests++;
        if (lives !== 2'd0 || state !== 3'd4 || freeze !== 1'b1 || enable !== 1'b1) begin
            n_fail++;
            $display("FAIL game_over: lives=%0d state=%0d frz=%b en=%b, want 0 4 1 1", lives, state, freeze, enable);
        end
        tick(1, 1, 0);
        n_tests++;
        if (lives !== 2'd0 || state !== 3'd4 || count_n !== 1'b1) begin
            n_fail++;
            $display("FAIL over_hold: lives=%0d state=%0d cn=%b, want 0 4 1", lives, state, count_n);
        end
    endtask

    task automatic test_simultaneous;
        tick(0, 0, 1);
        tick(1, 1, 0);
        n_tests++;
        if (lives !== 2'd2 || count_n !== 1'b1 || level !== 5'd0 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL goal_and_hit: lives=%0d cn=%b level=%0d state=%0d, want 2 1 0 3", lives, count_n, level, state);
        end
    endtask

    task automatic test_reset_mid_banner;
        repeat (BANNER) tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        n_tests++;
        if (state !== 3'd2 || level !== 5'd1) begin
            n_fail++;
            $display("FAIL pre_reset: state=%0d level=%0d, want 2 1", state, level);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({state, level, lives, freeze, enable, count_n} !== {3'd0, 5'd0, 2'd3, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d level=%0d lives=%0d frz=%b en=%b cn=%b, want 0 0 3 1 0 1",
                     state, level, lives, freeze, enable, count_n);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random;
        int ms, ml, mv, left, mp;
        logic g, h, s, mcn, mclr;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ms = S_IDLE; ml = 0; mv = LIVES; left = 0; mp = 200;
        for (int c = 0; c < 800; c++) begin
            s = ($urandom_range(0, 7) == 0);
            g = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 5) == 0);
            mp = period_of(ml);
            mcn = 1'b1;
            mclr = 1'b0;
            if ((ms == S_IDLE || ms == S_OVER || ms == S_WIN) && s) begin
                ms = S_PLAY; ml = 0; mv = LIVES; mclr = 1'b1;
            end else if (ms == S_PLAY && h) begin
                mv = mv - 1;
                if (mv == 0) ms = S_OVER;
                else begin ms = S_DIE; left = BANNER; end
            end else if (ms == S_PLAY && g) begin
                mcn = 1'b0;
                if (ml == MAXL - 1) ms = S_WIN;
                else begin ml = ml + 1; ms = S_LU; left = BANNER; end
            end else if (ms == S_LU || ms == S_DIE) begin
                left = left - 1;
                if (left == 0) ms = S_PLAY;
            end
            tick(g, h, s);
            n_tests++;
            if ({state, level, lives, count_n, clear, enable, freeze, period} !==
                {3'(ms), 5'(ml), 2'(mv), mcn, mclr, (ms != S_IDLE), (ms != S_PLAY), 8'(mp)}) begin
                n_fail++;
                $display("FAIL random[%0d]: got st=%0d lv=%0d li=%0d cn=%b clr=%b en=%b frz=%b per=%0d want st=%0d lv=%0d li=%0d cn=%b clr=%b en=%b frz=%b per=%0d",
                         c, state, level, lives, count_n, clear, enable, freeze, period,
                         ms, ml, mv, mcn, mclr, (ms != S_IDLE), (ms != S_PLAY), mp);
            end
        end
    endtask

    initial begin
        #2;
        test_reset;
        test_start;
        test_goal;
        test_win;
        test_lives;
        test_simultaneous;
        test_reset_mid_banner;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/level_progress_sequencer.md
Name: level_progress_sequencer

Overview:
FSM that sequences the Frogger level-progress counter. It turns the game events start, frog-reached-goal and frog-hit into the counter's control strobes: clear, active-low count and game-enable. It also tracks lives and the current level, holds timed banner phases between rounds, and outputs the lane period for the obstacle-speed logic. It sits between the input/collision logic and the level-progress counter plus the lane generators.

Parameters:
LEVEL_WIDTH, 5, width of level index and level output.
MAX_LEVEL, 16, number of levels; completing level MAX_LEVEL-1 wins the game.
LIVES_WIDTH, 2, width of the lives counter.
LIVES_INIT, 3, lives loaded at game start.
BANNER_CYCLES, 50000000, clocks spent in LEVEL_UP and DYING phases (1 s at 50 MHz).
TIMER_WIDTH, 26, banner timer width; must satisfy 2^TIMER_WIDTH > BANNER_CYCLES.
PERIOD_WIDTH, 8, width of the lane period output.
BASE_PERIOD, 200, lane period at level 0.
PERIOD_STEP, 10, period decrement per level.
MIN_PERIOD, 40, lane period floor.

Ports:
SC_LEVELPROGRESSCOUNTER_CLOCK_50  in  1  system clock, 50 MHz.
SC_LEVELPROGRESSCOUNTER_RESET_InHigh  in  1  asynchronous, active-high reset.
start_in  in  1  one-cycle synchronous start pulse (debounced elsewhere).
goal_in  in  1  one-cycle pulse: frog reached home row.
hit_in  in  1  one-cycle pulse: frog collided or drowned.
count_n_out  out  1  active-low one-cycle count strobe to the counter.
clear_out  out  1  one-cycle clear strobe to the counter (StartCount).
enable_out  out  1  game-active level to the counter (FinishedGame); the counter holds 0 while this is low.
freeze_out  out  1  freezes lanes and frog.
state_out  out  3  encoded FSM state for display.
level_out  out  LEVEL_WIDTH  current level index.
lives_out  out  LIVES_WIDTH  remaining lives.
lane_period_out  out  PERIOD_WIDTH  lane step period.

Behaviour:
- Reset (async) values: state=IDLE, level=0, lives=LIVES_INIT, timer=0, count_n_out=1, clear_out=0, enable_out=0, freeze_out=1.
- State encodings: IDLE=0, PLAYING=1, LEVEL_UP=2, DYING=3, GAME_OVER=4, WIN=5. All outputs are registered.
- IDLE: on start_in go to PLAYING. In that same transition cycle load level=0 and lives=LIVES_INIT. clear_out=1 for exactly one cycle, visible in the first PLAYING cycle.
- PLAYING: freeze_out=0, enable_out=1.
  - goal_in with hit_in=0: count_n_out=0 for one cycle and level++.
  - If the old level was MAX_LEVEL-1, go to WIN and hold level at MAX_LEVEL-1 (no increment).
  - Otherwise go to LEVEL_UP and load timer=BANNER_CYCLES-1.
  - hit_in: lives--. If the old lives value was 1, go to GAME_OVER with lives=0. Otherwise go to DYING and load the timer.
  - goal_in and hit_in in the same cycle: hit wins; no count strobe and no level change.
- LEVEL_UP / DYING: freeze_out=1, enable_out=1. The timer decrements each clock; when timer==0 the next state is PLAYING, so the phase lasts exactly BANNER_CYCLES clocks. goal_in and hit_in are ignored.
- GAME_OVER / WIN: freeze_out=1, enable_out=1; level_out and lives_out hold. start_in restarts exactly as from IDLE: clear strobe, level=0, lives=LIVES_INIT, state=PLAYING.
- start_in is ignored in PLAYING, LEVEL_UP and DYING.
- count_n_out and clear_out are never asserted in the same cycle.
- lane_period_out = max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD).
  - Compute at PERIOD_WIDTH+LEVEL_WIDTH bits so the subtraction cannot underflow.
  - Registered; updates one cycle after a level change.
- Reset mid-banner or mid-game: immediate return to the reset values; the timer is discarded.

Decomposition:
- Shared package/header holds:
  - the state encoding localparams (IDLE..WIN, 3 bits);
  - default BASE_PERIOD, PERIOD_STEP and MIN_PERIOD.
- One sub-module, level_banner_timer: loadable down-counter with a load input and a zero flag. It is reused for the LEVEL_UP and DYING phases.
- The FSM, lives counter, level counter and period computation stay in the top module.

Test Plan:
All scenarios use MAX_LEVEL=3, LIVES_INIT=3, BANNER_CYCLES=4.
1. Reset then start_in pulse -> clear_out=1 for 1 cycle, state=1, level=0, lives=3, lane_period_out=200, freeze_out=0.
2. In PLAYING, goal_in pulse -> count_n_out=0 for exactly 1 cycle, level=1, state=2 for 4 clocks then 1, lane_period_out=190; goal_in during LEVEL_UP is ignored.
3. Goals at level 2 -> state=5 (WIN), level held at 2, count_n_out pulses once. start_in -> state=1, level=0, clear_out pulse.
4. Three hit_in pulses, each separated by DYING phases -> lives 2,1 with state=3 (4 clocks each), then lives=0, state=4. Further hit_in has no effect.
5. goal_in and hit_in in the same cycle -> lives decremented, count_n_out stays 1, level unchanged, state=3.
6. Assert reset during cycle 2 of LEVEL_UP -> immediately state=0, level=0, lives=3, freeze_out=1, enable_out=0, count_n_out=1.
